// File: rtl/seven_seg_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver_pkg
// Description : Shared definitions for the seven-segment scan driver.
//               - Active-high gfedcba glyphs for hex digits 0-F.
//               - SEG_OFF mask, all segments dark in active-high form.
//               - clog2 helper whose result is never below 1.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_scan_driver_pkg;

  // Active-high glyphs. Bit order is g,f,e,d,c,b,a from bit 6 down to bit 0.
  localparam logic [6:0] GLYPH_0 = 7'b0111111;
  localparam logic [6:0] GLYPH_1 = 7'b0000110;
  localparam logic [6:0] GLYPH_2 = 7'b1011011;
  localparam logic [6:0] GLYPH_3 = 7'b1001111;
  localparam logic [6:0] GLYPH_4 = 7'b1100110;
  localparam logic [6:0] GLYPH_5 = 7'b1101101;
  localparam logic [6:0] GLYPH_6 = 7'b1111101;
  localparam logic [6:0] GLYPH_7 = 7'b0000111;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1100111;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b1111100;
  localparam logic [6:0] GLYPH_C = 7'b1011000;
  localparam logic [6:0] GLYPH_D = 7'b1011110;
  localparam logic [6:0] GLYPH_E = 7'b1111001;
  localparam logic [6:0] GLYPH_F = 7'b1110001;

  // All segments dark, in active-high form.
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Ceiling log2 with a floor of 1, so a single-entry range still gets a
  // one-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_driver_glyph_rom.sv
`default_nettype none
// ============================================================================
// Module      : seg_glyph_rom
// Description : Combinational hex-nibble to seven-segment glyph lookup.
//               The output polarity is selected by ACTIVE_LOW.
// Ports       : nibble_i [3:0] - hex digit to render
//               seg_o    [6:0] - gfedcba segment pattern at pin polarity
// Revision    : 1.0 - initial release
// ============================================================================
module seg_glyph_rom
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_OFF;
    case (nibble_i)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = SEG_OFF;
    endcase
    seg_o = (ACTIVE_LOW != 0) ? ~glyph : glyph;
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Multiplexed seven-segment display driver. Latches a value and
//               decimal points into a pending register. Pending data moves to
//               the displayed (active) register only at frame wrap, so a frame
//               never mixes old and new data. Supports leading-zero blanking.
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous, active-high
//               enable     - 0 blanks the display and freezes the scan
//               load       - one-cycle strobe capturing value/dp_in
//               value      - one nibble per digit, digit 0 = LS nibble
//               dp_in      - per-digit decimal point, 1 = lit
//               blank_lz   - enables leading-zero blanking
//               seg        - registered gfedcba segments
//               dp         - registered decimal point
//               an         - registered one-hot anode select
//               digit_idx  - index of the digit currently driven
//               frame_done - one-cycle pulse in the cycle after a scan wrap
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*DIGITS-1:0]       value,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic                      blank_lz,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [DIGITS-1:0]         an,
  output logic [clog2(DIGITS)-1:0]  digit_idx,
  output logic                      frame_done
);

  localparam int IW = clog2(DIGITS);
  localparam int PW = clog2(SCAN_DIV);
  localparam logic [IW-1:0]     IDX_LAST     = IW'(DIGITS - 1);
  localparam logic [PW-1:0]     PCNT_LAST    = PW'(SCAN_DIV - 1);
  localparam logic [6:0]        SEG_OFF_PINS = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic              DP_OFF_PIN   = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF_PINS  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                pend_v_q, pend_v_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q;

  logic                tick, wrap, blank, dp_lit;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   onehot, zero_from;
  logic [6:0]          rom_seg;

  // Prescaler, digit index and the pending/active data hand-off.
  always_comb begin
    tick       = enable && (pcnt_q == PCNT_LAST);
    wrap       = tick && (idx_q == IDX_LAST);
    pcnt_d     = pcnt_q;
    idx_d      = idx_q;
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_v_d   = pend_v_q;

    if (enable) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      pend_v_d   = 1'b1;
    end

    // A load on the wrap edge is newer than anything pending, so it goes
    // straight to active and the older pending data is dropped.
    if (wrap) begin
      pend_v_d = 1'b0;
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp_in;
      end else if (pend_v_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
    end
  end

  // Output decode works from next-state index and data, so all outputs
  // register together on the edge that moves the scan.
  always_comb begin
    // zero_from[i] is set when nibbles i..DIGITS-1 of the active value are zero.
    zero_from = '0;
    zero_from[DIGITS-1] = (act_val_d[4*(DIGITS-1) +: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (act_val_d[4*i +: 4] == 4'h0);
    end

    nibble = 4'h0;
    dp_lit = 1'b0;
    onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nibble    = act_val_d[4*i +: 4];
        dp_lit    = act_dp_d[i];
        onehot[i] = 1'b1;
      end
    end

    blank = blank_lz && (idx_d != '0) && zero_from[idx_d];

    seg_d = (!enable || blank) ? SEG_OFF_PINS : rom_seg;
    dp_d  = enable ? (dp_lit ^ DP_OFF_PIN) : DP_OFF_PIN;
    an_d  = enable ? (onehot ^ AN_OFF_PINS) : AN_OFF_PINS;
  end

  seg_glyph_rom #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_glyph_rom (
    .nibble_i (nibble),
    .seg_o    (rom_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_v_q     <= 1'b0;
      seg_q        <= SEG_OFF_PINS;
      dp_q         <= DP_OFF_PIN;
      an_q         <= AN_OFF_PINS;
      frame_done_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_v_q     <= pend_v_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= wrap;
    end
  end

  // idx_q is itself registered from idx_d, so it is aligned with seg/an.
  assign digit_idx  = idx_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_driver
// Description : Directed self-checking bench for seven_seg_scan_driver with
//               DIGITS=4, SCAN_DIV=4, active-low segments and anodes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  // Expected active-low segment patterns (inverted gfedcba glyphs).
  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SB  = 7'b0000011;
  localparam logic [6:0] SC  = 7'b0100111;
  localparam logic [6:0] SD  = 7'b0100001;
  localparam logic [6:0] OFF = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  // Advance to the negedge where frame_done is high (first cycle of a frame).
  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    int bad;
    reset = 1'b1; enable = 1'b1; load = 1'b1; value = 16'h1234;
    dp_in = 4'b0000; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL rst_an: got %b exp 1111", an); end
    checks++; if (seg !== OFF) begin errors++; $display("FAIL rst_seg: got %b exp %b", seg, OFF); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp: got %b exp 1", dp); end
    checks++; if (digit_idx !== 2'd0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL rst_idx_fd: got idx=%0d fd=%b exp idx=0 fd=0", digit_idx, frame_done);
    end
    reset = 1'b0;
    @(negedge clk);
    load = 1'b0;
    sync_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_sync: frame_done got 0 exp 1"); end
    checks++; if (seg !== S4 || an !== 4'b1110 || digit_idx !== 2'd0) begin
      errors++; $display("FAIL rst_digit0: got seg=%b an=%b idx=%0d exp seg=%b an=1110 idx=0", seg, an, digit_idx, S4);
    end
    bad = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 3 && an !== 4'b1110) bad++;
      if (c == 4) begin
        checks++; if (seg !== S3 || an !== 4'b1101) begin
          errors++; $display("FAIL rst_digit1: got seg=%b an=%b exp seg=%b an=1101", seg, an, S3);
        end
      end
      if (c == 12) begin
        checks++; if (seg !== S1 || an !== 4'b0111) begin
          errors++; $display("FAIL rst_digit3: got seg=%b an=%b exp seg=%b an=0111", seg, an, S1);
        end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_dwell: got %0d short-dwell cycles exp 0", bad); end
  endtask

  task automatic test_tear_free;
    bit ok;
    int fd_cnt;
    sync_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tf_sync: frame_done got 0 exp 1"); end
    fd_cnt = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_cnt++;
      case (c)
        8: begin
          checks++; if (seg !== S2 || an !== 4'b1011) begin
            errors++; $display("FAIL tf_old_d2: got seg=%b an=%b exp seg=%b an=1011", seg, an, S2);
          end
        end
        12: begin
          checks++; if (seg !== S1) begin errors++; $display("FAIL tf_old_d3: got %b exp %b", seg, S1); end
        end
        16: begin
          checks++; if (seg !== SD || frame_done !== 1'b1 || digit_idx !== 2'd0) begin
            errors++; $display("FAIL tf_new_d0: got seg=%b fd=%b idx=%0d exp seg=%b fd=1 idx=0", seg, frame_done, digit_idx, SD);
          end
        end
        20: begin
          checks++; if (seg !== SC) begin errors++; $display("FAIL tf_new_d1: got %b exp %b", seg, SC); end
        end
        24: begin
          checks++; if (seg !== SB) begin errors++; $display("FAIL tf_new_d2: got %b exp %b", seg, SB); end
        end
        28: begin
          checks++; if (seg !== SA) begin errors++; $display("FAIL tf_new_d3: got %b exp %b", seg, SA); end
        end
        default: ;
      endcase
      value = 16'hABCD;
      load  = (c == 5);
    end
    checks++; if (fd_cnt != 2) begin errors++; $display("FAIL tf_frame_done_count: got %0d exp 2", fd_cnt); end
  endtask

  task automatic test_load_on_wrap;
    bit ok;
    int bad;
    sync_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lw_sync: frame_done got 0 exp 1"); end
    bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (seg === S1) bad++;
      if (c == 4) begin
        checks++; if (seg !== SC) begin errors++; $display("FAIL lw_old_d1: got %b exp %b", seg, SC); end
      end
      if (c == 16 || c == 20 || c == 24 || c == 28 || c == 32 || c == 36) begin
        checks++; if (seg !== S2) begin errors++; $display("FAIL lw_new_c%0d: got %b exp %b", c, seg, S2); end
      end
      if (c == 2)  value = 16'h1111;
      if (c == 15) value = 16'h2222;
      load = (c == 2) || (c == 15);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lw_stale_shown: got %0d cycles of 1 exp 0", bad); end
  endtask

  task automatic test_blank_lz;
    bit ok;
    blank_lz = 1'b1; value = 16'h0050; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    sync_frame(ok);
    checks++; if (!ok || seg !== S0 || an !== 4'b1110) begin
      errors++; $display("FAIL lz_d0: got ok=%b seg=%b an=%b exp ok=1 seg=%b an=1110", ok, seg, an, S0);
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++; if (seg !== S5) begin errors++; $display("FAIL lz_d1: got %b exp %b", seg, S5); end
      end
      if (c == 8 || c == 12) begin
        checks++; if (seg !== OFF) begin errors++; $display("FAIL lz_c%0d: got %b exp %b", c, seg, OFF); end
      end
    end
    value = 16'h0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    sync_frame(ok);
    checks++; if (!ok || seg !== S0) begin
      errors++; $display("FAIL lz0_d0: got ok=%b seg=%b exp ok=1 seg=%b", ok, seg, S0);
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 4 || c == 8 || c == 12) begin
        checks++; if (seg !== OFF) begin errors++; $display("FAIL lz0_c%0d: got %b exp %b", c, seg, OFF); end
      end
    end
  endtask

  task automatic test_dp_blank;
    bit ok;
    blank_lz = 1'b1; value = 16'h0001; dp_in = 4'b0100; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    sync_frame(ok);
    checks++; if (!ok || seg !== S1 || dp !== 1'b1 || an !== 4'b1110) begin
      errors++; $display("FAIL dp_d0: got ok=%b seg=%b dp=%b an=%b exp ok=1 seg=%b dp=1 an=1110", ok, seg, dp, an, S1);
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++; if (seg !== OFF || dp !== 1'b1) begin
          errors++; $display("FAIL dp_d1: got seg=%b dp=%b exp seg=%b dp=1", seg, dp, OFF);
        end
      end
      if (c == 8) begin
        checks++; if (seg !== OFF || dp !== 1'b0 || an !== 4'b1011) begin
          errors++; $display("FAIL dp_d2: got seg=%b dp=%b an=%b exp seg=%b dp=0 an=1011", seg, dp, an, OFF);
        end
      end
      if (c == 12) begin
        checks++; if (dp !== 1'b1 || an !== 4'b0111) begin
          errors++; $display("FAIL dp_d3: got dp=%b an=%b exp dp=1 an=0111", dp, an);
        end
      end
    end
  endtask

  task automatic test_enable_freeze;
    bit ok;
    int bad;
    sync_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_sync: frame_done got 0 exp 1"); end
    bad = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c >= 6 && c <= 15) begin
        if (an !== 4'b1111 || seg !== OFF || dp !== 1'b1 || digit_idx !== 2'd1) bad++;
      end
      if (c == 16 || c == 17) begin
        checks++; if (an !== 4'b1101 || digit_idx !== 2'd1) begin
          errors++; $display("FAIL en_resume_c%0d: got an=%b idx=%0d exp an=1101 idx=1", c, an, digit_idx);
        end
      end
      if (c == 18 || c == 21) begin
        checks++; if (an !== 4'b1011 || digit_idx !== 2'd2) begin
          errors++; $display("FAIL en_next_c%0d: got an=%b idx=%0d exp an=1011 idx=2", c, an, digit_idx);
        end
      end
      if (c == 22) begin
        checks++; if (an !== 4'b0111 || digit_idx !== 2'd3) begin
          errors++; $display("FAIL en_d3: got an=%b idx=%0d exp an=0111 idx=3", an, digit_idx);
        end
      end
      if (c == 5)  enable = 1'b0;
      if (c == 15) enable = 1'b1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL en_frozen: got %0d bad disabled cycles exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_tear_free();
    test_load_on_wrap();
    test_blank_lz();
    test_dp_blank();
    test_enable_freeze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
